alu_arbiter: RTL and testbench

- Shares one combinational ALU (2-bit opcode, NZCV flag outputs) between two requesters, e.g. execute stage (req 0) and address generation (req 1).
- Round-robin grant, valid/ready handshakes, one-entry registered response buffer.
- Owns the architectural NZCV flags register, written only by flag-setting operations.
- The ALU is external: this block drives its operands and opcode and samples its result and flags.

---
 rtl/alu_arb_pkg.sv | 32 +++
 rtl/alu_arbiter_rr_arb2.sv | 53 +++++
 rtl/alu_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types for the two-requester ALU arbiter:
//   alu_op_t    - 2-bit ALU opcode (ADD, SUB, AND, ORR)
//   flags_t     - packed {n,z,c,v} condition flags
//   rsp_state_t - response buffer state (EMPTY / FULL)
//   NREQ        - number of requesters sharing the ALU
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin grant. The pointer names the requester favoured when
// both request; it moves to the other requester only on an advance pulse
// (an accepted grant), never on idle cycles.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (pointer -> 0)
//   req_i       - request vector, bit i = requester i valid
//   advance_i   - the current grant was accepted this cycle
//   grant_o     - index of the granted requester (0 when nobody requests)
//   ptr_o       - current round-robin pointer
// -----------------------------------------------------------------------------
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic            grant_o,
    output logic            ptr_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = 1'b0;
        if (req_i[0] && req_i[1]) begin
            grant_o = ptr_q;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = ~grant_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters with a
// round-robin grant, a one-entry registered response buffer and the
// architectural NZCV flags register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and payload stable while valid && !ready,
// and valid never depends on ready. The response side follows the same rule
// with rsp_valid / rsp_ready.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   reqN_valid/ready           - requester N handshake (N = 0, 1)
//   reqN_a/b/op/sf             - requester N operands, opcode, set-flags
//   alu_a/alu_b/alu_op         - operands/opcode driven to the shared ALU
//   alu_result/alu_flags       - ALU result and {N,Z,C,V}
//   rsp_valid/ready            - response handshake
//   rsp_id/result/flags        - owner, result and flags of buffered response
//   nzcv                       - architectural flags register
//   dbg_state_o                - response buffer state (1 = FULL)
//   dbg_rr_ptr_o               - round-robin pointer
// Optional (macro ALU_ARB_STATS_EN):
//   grant0_cnt, grant1_cnt     - saturating per-requester accept counters
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req0_sf,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    input  logic             req1_sf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       nzcv,
    output logic             dbg_state_o,
    output logic             dbg_rr_ptr_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    rsp_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic             id_q, id_d;
    flags_t           nzcv_q, nzcv_d;

    logic [NREQ-1:0] req_vec;
    logic            grant;
    logic            rr_ptr;
    logic            can_accept;
    logic            accept;
    logic            grant_sf;
    alu_op_t         op_sel;

    assign req_vec = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_vec),
        .advance_i (accept),
        .grant_o   (grant),
        .ptr_o     (rr_ptr)
    );

    // A full buffer can still accept when its occupant leaves this same
    // cycle, which is what gives back-to-back throughput.
    assign can_accept = (state_q == RSP_EMPTY) || rsp_ready;
    assign accept     = can_accept && (|req_vec);

    assign req0_ready = can_accept && (grant == 1'b0);
    assign req1_ready = can_accept && (grant == 1'b1);

    // With no valid request the grant defaults to 0, so requester 0's fields
    // reach the ALU; the result is simply not captured.
    assign op_sel   = grant ? alu_op_t'(req1_op) : alu_op_t'(req0_op);
    assign alu_a    = grant ? req1_a : req0_a;
    assign alu_b    = grant ? req1_b : req0_b;
    assign alu_op   = op_sel;
    assign grant_sf = grant ? req1_sf : req0_sf;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        id_d     = id_q;
        nzcv_d   = nzcv_q;
        if (accept) begin
            state_d  = RSP_FULL;
            result_d = alu_result;
            flags_d  = flags_t'(alu_flags);
            id_d     = grant;
            if (grant_sf) begin
                nzcv_d = flags_t'(alu_flags);
            end
        end else if ((state_q == RSP_FULL) && rsp_ready) begin
            state_d = RSP_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RSP_EMPTY;
            result_q <= '0;
            flags_q  <= '0;
            id_q     <= 1'b0;
            nzcv_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            id_q     <= id_d;
            nzcv_q   <= nzcv_d;
        end
    end

    assign rsp_valid    = (state_q == RSP_FULL);
    assign rsp_id       = id_q;
    assign rsp_result   = result_q;
    assign rsp_flags    = flags_q;
    assign nzcv         = nzcv_q;
    assign dbg_state_o  = (state_q == RSP_FULL);
    assign dbg_rr_ptr_o = rr_ptr;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept && (grant == 1'b0) && (cnt0_q != '1)) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (accept && (grant == 1'b1) && (cnt1_q != '1)) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant0_cnt = cnt0_q;
    assign grant1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             req0_valid, req0_ready, req0_sf;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [1:0]       req0_op;
    logic             req1_valid, req1_ready, req1_sf;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [1:0]       alu_op;
    logic [3:0]       alu_flags;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags, nzcv;
    logic             dbg_state, dbg_rr_ptr;

    int n_cmp = 0;
    int n_err = 0;
    logic g;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant0_cnt, grant1_cnt;
    logic [1:0]  s_grant0_cnt, s_grant1_cnt;
    logic             s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
    logic [WIDTH-1:0] s_alu_a, s_alu_b, s_rsp_result;
    logic [1:0]       s_alu_op;
    logic [3:0]       s_rsp_flags, s_nzcv;
    logic             s_dbg_state, s_dbg_rr_ptr;
`endif

    alu_arbiter #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_sf(req0_sf),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_sf(req1_sf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .nzcv(nzcv),
        .dbg_state_o(dbg_state), .dbg_rr_ptr_o(dbg_rr_ptr)
`ifdef ALU_ARB_STATS_EN
        , .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
`endif
    );

`ifdef ALU_ARB_STATS_EN
    // Narrow-counter copy sharing the same stimulus, for saturation.
    alu_arbiter #(.WIDTH(WIDTH), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_sf(req0_sf),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_sf(req1_sf),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_result(s_rsp_result), .rsp_flags(s_rsp_flags), .nzcv(s_nzcv),
        .dbg_state_o(s_dbg_state), .dbg_rr_ptr_o(s_dbg_rr_ptr),
        .grant0_cnt(s_grant0_cnt), .grant1_cnt(s_grant1_cnt)
    );
`endif

    // ---------------- external ALU model ----------------
    logic [WIDTH:0] sum;
    always_comb begin
        sum        = '0;
        alu_result = '0;
        alu_flags  = '0;
        case (alu_op)
            2'b00: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum[WIDTH-1:0];
                alu_flags[1] = sum[WIDTH];
                alu_flags[0] = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                               (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
            end
            2'b01: begin
                sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
                alu_result = sum[WIDTH-1:0];
                alu_flags[1] = sum[WIDTH];
                alu_flags[0] = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                               (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
            end
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
        alu_flags[3] = alu_result[WIDTH-1];
        alu_flags[2] = (alu_result == '0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [1:0] op,
                            input logic sf);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_sf = sf;
    endtask

    task automatic set_req1(input logic v, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [1:0] op,
                            input logic sf);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_sf = sf;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        rsp_ready = 1'b0;
        set_req0(1'b0, '0, '0, 2'b00, 1'b0);
        set_req1(1'b0, '0, '0, 2'b00, 1'b0);
        tick();
        tick();

        chk("reset_rsp_valid",  rsp_valid,  0);
        chk("reset_rsp_id",     rsp_id,     0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_rsp_flags",  rsp_flags,  0);
        chk("reset_nzcv",       nzcv,       0);
        chk("reset_rr_ptr",     dbg_rr_ptr, 0);
        chk("reset_state",      dbg_state,  0);
        reset = 1'b0;

        // req0 ADD 10+3, set flags
        set_req0(1'b1, 32'h0000_000A, 32'h0000_0003, 2'b00, 1'b1);
        rsp_ready = 1'b1;
        #1;
        chk("add_req0_ready", req0_ready, 1);
        chk("add_req1_ready", req1_ready, 0);
        chk("add_alu_a",      alu_a,      32'h0000_000A);
        chk("add_alu_b",      alu_b,      32'h0000_0003);
        chk("add_alu_op",     alu_op,     2'b00);
        tick();
        req0_valid = 1'b0;
        chk("add_rsp_valid",  rsp_valid,  1);
        chk("add_rsp_id",     rsp_id,     0);
        chk("add_rsp_result", rsp_result, 13);
        chk("add_rsp_flags",  rsp_flags,  4'b0000);
        chk("add_nzcv",       nzcv,       4'b0000);
        chk("add_rr_ptr",     dbg_rr_ptr, 1);

        // req1 SUB 3-3 without flag update; also same-cycle drain+refill
        set_req1(1'b1, 32'd3, 32'd3, 2'b01, 1'b0);
        #1;
        chk("sub33_req1_ready", req1_ready, 1);
        chk("sub33_req0_ready", req0_ready, 0);
        chk("sub33_alu_op",     alu_op,     2'b01);
        tick();
        req1_valid = 1'b0;
        chk("sub33_rsp_id",     rsp_id,     1);
        chk("sub33_rsp_result", rsp_result, 0);
        chk("sub33_rsp_flags",  rsp_flags,  4'b0110);
        chk("sub33_nzcv",       nzcv,       4'b0000);
        chk("sub33_rr_ptr",     dbg_rr_ptr, 0);

        // req0 SUB 3-5 with flag update: negative, borrow
        set_req0(1'b1, 32'd3, 32'd5, 2'b01, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk("sub35_rsp_result", rsp_result, 32'hFFFF_FFFE);
        chk("sub35_rsp_flags",  rsp_flags,  4'b1000);
        chk("sub35_nzcv",       nzcv,       4'b1000);

        // req1 AND without flag update: nzcv must hold
        set_req1(1'b1, 32'h0000_00F0, 32'h0000_003C, 2'b10, 1'b0);
        tick();
        req1_valid = 1'b0;
        chk("and_rsp_result", rsp_result, 32'h0000_0030);
        chk("and_rsp_flags",  rsp_flags,  4'b0000);
        chk("and_nzcv",       nzcv,       4'b1000);

        // idle cycle drains the buffer; pointer does not move
        tick();
        chk("idle_rsp_valid",  rsp_valid,  0);
        chk("idle_rr_ptr",     dbg_rr_ptr, 0);
        chk("idle_req0_ready", req0_ready, 1);

        // both valid every cycle: grants alternate 0,1,0,1
        set_req0(1'b1, 32'd1, 32'd1, 2'b00, 1'b1);
        set_req1(1'b1, 32'h0000_0010, 32'h0000_0001, 2'b11, 1'b0);
        g = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_req0_ready", req0_ready, (g == 1'b0));
            chk("alt_req1_ready", req1_ready, (g == 1'b1));
            tick();
            chk("alt_rsp_valid",  rsp_valid,  1);
            chk("alt_rsp_id",     rsp_id,     g);
            chk("alt_rsp_result", rsp_result, g ? 32'h0000_0011 : 32'd2);
            g = ~g;
        end
        chk("alt_nzcv", nzcv, 4'b0000);

        // backpressure: buffer holds, nobody is ready
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_req0_ready", req0_ready, 0);
            chk("bp_req1_ready", req1_ready, 0);
            tick();
            chk("bp_rsp_valid",  rsp_valid,  1);
            chk("bp_rsp_id",     rsp_id,     1);
            chk("bp_rsp_result", rsp_result, 32'h0000_0011);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", req0_ready, 1);
        chk("bp_release_req1_ready", req1_ready, 0);
        tick();
        chk("bp_refill_rsp_valid",  rsp_valid,  1);
        chk("bp_refill_rsp_id",     rsp_id,     0);
        chk("bp_refill_rsp_result", rsp_result, 32'd2);
        chk("bp_refill_rr_ptr",     dbg_rr_ptr, 1);

        // load nzcv with a non-zero value before the reset test
        req1_valid = 1'b0;
        set_req0(1'b1, 32'd3, 32'd5, 2'b01, 1'b1);
        #1;
        chk("pre_rst_req0_ready", req0_ready, 1);
        tick();
        chk("pre_rst_nzcv",   nzcv,       4'b1000);
        chk("pre_rst_rr_ptr", dbg_rr_ptr, 1);

        // req1 pending while FULL and stalled, then reset
        req0_valid = 1'b0;
        set_req1(1'b1, 32'd7, 32'd7, 2'b01, 1'b1);
        rsp_ready = 1'b0;
        #1;
        chk("stall_req1_ready", req1_ready, 0);
        tick();
        chk("stall_rsp_valid",  rsp_valid,  1);
        chk("stall_rsp_result", rsp_result, 32'hFFFF_FFFE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_rsp_valid",  rsp_valid,  0);
        chk("midrst_nzcv",       nzcv,       4'b0000);
        chk("midrst_rr_ptr",     dbg_rr_ptr, 0);
        chk("midrst_rsp_result", rsp_result, 0);

        // both valid after reset: requester 0 first
        req0_valid = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        chk("postrst_req0_ready", req0_ready, 1);
        chk("postrst_req1_ready", req1_ready, 0);
        tick();
        chk("postrst_rsp_id",    rsp_id,    0);
        chk("postrst_rsp_valid", rsp_valid, 1);

`ifdef ALU_ARB_STATS_EN
        // 5 req0 accepts then 3 req1 accepts from a fresh reset
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("stats_reset_cnt0", grant0_cnt, 0);
        chk("stats_reset_cnt1", grant1_cnt, 0);
        set_req0(1'b1, 32'd1, 32'd2, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        req0_valid = 1'b0;
        set_req1(1'b1, 32'd1, 32'd2, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        req1_valid = 1'b0;
        chk("stats_cnt0",       grant0_cnt,   5);
        chk("stats_cnt1",       grant1_cnt,   3);
        chk("stats_small_cnt0", s_grant0_cnt, 3);
        chk("stats_small_cnt1", s_grant1_cnt, 3);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
